// File: rtl/nibble_serial_addsub_ctrl.sv
// Wide add/subtract controller that time-multiplexes one external 4-bit full adder,
// one nibble per clock, LSB first, under a start/ready/done handshake.
module nibble_serial_addsub_ctrl #(
  parameter int NUM_NIBBLES = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       op_sub_i,
  input  logic [4*NUM_NIBBLES-1:0]   a_i,
  input  logic [4*NUM_NIBBLES-1:0]   b_i,
  output logic                       ready_o,
  output logic                       busy_o,
  output logic [3:0]                 fa_a_o,
  output logic [3:0]                 fa_b_o,
  output logic                       fa_cin_o,
  input  logic [3:0]                 fa_sum_i,
  input  logic                       fa_cout_i,
  output logic [4*NUM_NIBBLES-1:0]   result_o,
  output logic                       carry_o,
  output logic                       overflow_o,
  output logic                       done_o
);

  localparam int W  = 4 * NUM_NIBBLES;
  localparam int CW = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    opa_q, opa_d;
  logic [W-1:0]    opb_q, opb_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic [CW+1:0]   bit_idx;

  assign bit_idx = {cnt_q, 2'b00};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    ready_o  = 1'b0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    fa_a_o   = 4'h0;
    fa_b_o   = 4'h0;
    fa_cin_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          // Subtract is A + ~B + 1: the +1 enters as the first carry-in.
          opa_d   = a_i;
          opb_d   = op_sub_i ? ~b_i : b_i;
          carry_d = op_sub_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy_o   = 1'b1;
        fa_a_o   = opa_q[bit_idx +: 4];
        fa_b_o   = opb_q[bit_idx +: 4];
        fa_cin_o = carry_q;
        result_d[bit_idx +: 4] = fa_sum_i;
        carry_d  = fa_cout_i;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cout_d  = fa_cout_i;
          ovf_d   = (opa_q[W-1] == opb_q[W-1]) && (fa_sum_i[3] != opa_q[W-1]);
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign result_o   = result_q;
  assign carry_o    = cout_q;
  assign overflow_o = ovf_q;

endmodule
